calc_entry_sequencer: RTL and testbench

//  Keypad front-end for the UInt16 calculator datapath. Builds operands A and B from decimal

---
 rtl/calc_entry_sequencer_pkg.sv | 28 ++
 rtl/calc_entry_sequencer_digit_accumulator.sv | 28 ++
 rtl/calc_entry_sequencer.sv | 165 ++++++++++++++++
 tb/tb_calc_entry_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_entry_sequencer_pkg.sv
// Shared types for the calculator keypad front-end: operand type, operation
// codes, entry-sequencer states and the digit key width.
package calc_entry_sequencer_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [15:0] UInt16;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      DIV = 2'd2,
      MUL = 2'd3
   } OpCode;

   typedef enum logic [1:0] {
      S_A   = 2'd0,
      S_B   = 2'd1,
      S_RES = 2'd2,
      S_ERR = 2'd3
   } EntryState;

   // One-hot select vector ordered {multiply, divide, subtract, add}.
   function automatic logic [3:0] op_onehot(input OpCode op);
      return 4'b0001 << op;
   endfunction

endpackage

// File: rtl/calc_entry_sequencer_digit_accumulator.sv
// Combinational digit accumulator: acc*RADIX + digit evaluated four bits wider
// than the operand so that an overflowing keystroke can be detected and rejected.
module digit_accumulator
   import calc_entry_sequencer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int RADIX = 10
) (
   input  logic [WIDTH-1:0]   acc,
   input  logic [DIGIT_W-1:0] digit,
   output logic [WIDTH-1:0]   acc_next,
   output logic               fits,
   output logic               digit_ok
);

   localparam int EXT_W = WIDTH + 4;

   logic [EXT_W-1:0] wide;

   // Widened multiply-add; the upper four bits flag a result beyond 2^WIDTH-1.
   always_comb begin
      wide     = EXT_W'(acc) * EXT_W'(RADIX) + EXT_W'(digit);
      acc_next = wide[WIDTH-1:0];
      fits     = (wide[EXT_W-1:WIDTH] == '0);
      digit_ok = ({28'd0, digit} < $unsigned(RADIX));
   end

endmodule

// File: rtl/calc_entry_sequencer.sv
// Keypad front-end for the calculator datapath: builds operands A and B from
// digit keys, holds the selected operation, and captures the calculator result
// on '='. Key priority per cycle: clear > equals > op > digit.
// Optional feature macro: CALC_CHAIN_EN -- an op key while a result is shown
// carries that result into A and starts entering B (3+4+5 chaining).
module calc_entry_sequencer
   import calc_entry_sequencer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int RADIX = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               equals,
   input  logic               op_valid,
   input  logic [1:0]         op_code,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit,
   input  logic [WIDTH-1:0]   calc_result,
   input  logic               calc_invalid,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   output logic               add,
   output logic               subtract,
   output logic               divide,
   output logic               multiply,
   output logic [WIDTH-1:0]   display,
   output logic               error,
   output logic               overflow
);

   EntryState        state, state_nx;
   OpCode            op, op_nx;
   logic [WIDTH-1:0] a_nx, b_nx, result_reg, result_nx;
   logic             b_entered, b_entered_nx, overflow_nx;

   logic [WIDTH-1:0] acc_in, acc_next;
   logic             fits, digit_ok;

   // Single accumulator shared by both operands; B is the target only in S_B.
   assign acc_in = (state == S_B) ? b : a;

   digit_accumulator #(
      .WIDTH (WIDTH),
      .RADIX (RADIX)
   ) u_acc (
      .acc      (acc_in),
      .digit    (digit),
      .acc_next (acc_next),
      .fits     (fits),
      .digit_ok (digit_ok)
   );

   // State and operand registers; reset discards any partial entry at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_A;
         op         <= ADD;
         a          <= '0;
         b          <= '0;
         result_reg <= '0;
         b_entered  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nx;
         op         <= op_nx;
         a          <= a_nx;
         b          <= b_nx;
         result_reg <= result_nx;
         b_entered  <= b_entered_nx;
         overflow   <= overflow_nx;
      end
   end

   // Next-state logic: only the highest-priority key present acts this cycle.
   always_comb begin
      state_nx     = state;
      op_nx        = op;
      a_nx         = a;
      b_nx         = b;
      result_nx    = result_reg;
      b_entered_nx = b_entered;
      overflow_nx  = overflow;

      if (clear) begin
         state_nx     = S_A;
         op_nx        = ADD;
         a_nx         = '0;
         b_nx         = '0;
         result_nx    = '0;
         b_entered_nx = 1'b0;
         overflow_nx  = 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (equals) begin
                  // nothing to evaluate yet
               end else if (op_valid) begin
                  op_nx        = OpCode'(op_code);
                  b_nx         = '0;
                  b_entered_nx = 1'b0;
                  state_nx     = S_B;
               end else if (digit_valid && digit_ok) begin
                  if (fits) a_nx = acc_next;
                  else      overflow_nx = 1'b1;
               end
            end
            S_B: begin
               if (equals) begin
                  if (b_entered) begin
                     if ((op == DIV && b == '0) || calc_invalid) begin
                        state_nx = S_ERR;
                     end else begin
                        result_nx = calc_result;
                        state_nx  = S_RES;
                     end
                  end
               end else if (op_valid) begin
                  // a second op key only corrects the op before B is started
                  if (!b_entered) op_nx = OpCode'(op_code);
               end else if (digit_valid && digit_ok) begin
                  b_entered_nx = 1'b1;
                  if (fits) b_nx = acc_next;
                  else      overflow_nx = 1'b1;
               end
            end
            S_RES: begin
               if (equals) begin
                  // result already shown
               end else if (op_valid) begin
`ifdef CALC_CHAIN_EN
                  a_nx         = result_reg;
                  op_nx        = OpCode'(op_code);
                  b_nx         = '0;
                  b_entered_nx = 1'b0;
                  state_nx     = S_B;
`endif
               end else if (digit_valid && digit_ok) begin
                  a_nx     = WIDTH'(digit);
                  state_nx = S_A;
               end
            end
            default: begin
               // S_ERR: only clear leaves this state
            end
         endcase
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      {multiply, divide, subtract, add} = 4'b0000;
      if (state == S_B || state == S_RES)
         {multiply, divide, subtract, add} = op_onehot(op);
      error = (state == S_ERR);
      case (state)
         S_A:     display = a;
         S_B:     display = b_entered ? b : a;
         S_RES:   display = result_reg;
         default: display = '0;
      endcase
   end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer: an arithmetic model of the keypad
// rules, a stand-in calculator, per-cycle comparison and literal spot checks.
module tb_calc_entry_sequencer;
   import calc_entry_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0, equals = 1'b0, op_valid = 1'b0, digit_valid = 1'b0;
   logic [1:0] op_code = 2'd0;
   logic [3:0] digit = 4'd0;
   UInt16      calc_result, a, b, display;
   logic       calc_invalid, add, subtract, divide, multiply, error, overflow;
   logic       inj_invalid = 1'b0;

   int checks = 0;
   int errors = 0;
   bit checking = 0;

   // model: operands, op, shown result, and which phase of entry we are in
   longint m_a, m_b, m_res;
   int     m_op;
   bit     m_in_b, m_b_ent, m_has_res, m_err, m_ovf;

   calc_entry_sequencer dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .equals(equals),
      .op_valid(op_valid), .op_code(op_code), .digit_valid(digit_valid),
      .digit(digit), .calc_result(calc_result), .calc_invalid(calc_invalid),
      .a(a), .b(b), .add(add), .subtract(subtract), .divide(divide),
      .multiply(multiply), .display(display), .error(error), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // stand-in for the downstream combinational calculator
   always_comb begin
      calc_result  = '0;
      calc_invalid = inj_invalid;
      if (add)           calc_result = a + b;
      else if (subtract) calc_result = a - b;
      else if (multiply) calc_result = a * b;
      else if (divide) begin
         if (b != 0) calc_result = a / b;
         else        calc_invalid = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint arith(input int op, input longint x, input longint y);
      case (op)
         0:       return (x + y) % 65536;
         1:       return (x - y + 65536) % 65536;
         2:       return x / y;
         default: return (x * y) % 65536;
      endcase
   endfunction

   task automatic model_reset();
      m_a = 0; m_b = 0; m_res = 0; m_op = 0;
      m_in_b = 0; m_b_ent = 0; m_has_res = 0; m_err = 0; m_ovf = 0;
   endtask

   task automatic model_step(input bit c, input bit e, input bit ov, input int oc,
                             input bit dv, input int d);
      longint v;
      if (c) model_reset();
      else if (m_err) begin end
      else if (e) begin
         if (m_in_b && m_b_ent) begin
            m_in_b = 0;
            if ((m_op == 2 && m_b == 0) || inj_invalid) m_err = 1;
            else begin m_res = arith(m_op, m_a, m_b); m_has_res = 1; end
         end
      end else if (ov) begin
         if (m_in_b) begin
            if (!m_b_ent) m_op = oc;
         end else if (m_has_res) begin
`ifdef CALC_CHAIN_EN
            m_a = m_res; m_op = oc; m_b = 0; m_b_ent = 0;
            m_has_res = 0; m_in_b = 1;
`endif
         end else begin
            m_op = oc; m_b = 0; m_b_ent = 0; m_in_b = 1;
         end
      end else if (dv && d < 10) begin
         if (m_has_res) begin
            m_a = d; m_has_res = 0;
         end else begin
            v = (m_in_b ? m_b : m_a) * 10 + d;
            if (m_in_b) m_b_ent = 1;
            if (v > 65535) m_ovf = 1;
            else if (m_in_b) m_b = v;
            else m_a = v;
         end
      end
   endtask

   function automatic logic [31:0] exp_sel();
      if (!m_err && (m_in_b || m_has_res)) return 32'(1) << m_op;
      return 32'd0;
   endfunction

   function automatic logic [31:0] exp_disp();
      if (m_err)                return 32'd0;
      if (m_has_res)            return 32'(m_res);
      if (m_in_b && m_b_ent)    return 32'(m_b);
      return 32'(m_a);
   endfunction

   // per-cycle comparison against the model, half a cycle after each edge
   always @(negedge clk) begin
      if (checking) begin
         chk("a", 32'(a), 32'(m_a));
         chk("b", 32'(b), 32'(m_b));
         chk("op_selects", {28'd0, multiply, divide, subtract, add}, exp_sel());
         chk("display", 32'(display), exp_disp());
         chk("error", 32'(error), 32'(m_err));
         chk("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic key(input bit c, input bit e, input bit ov, input int oc,
                      input bit dv, input int d);
      @(negedge clk);
      clear = c; equals = e; op_valid = ov; op_code = 2'(oc);
      digit_valid = dv; digit = 4'(d);
      @(posedge clk);
      model_step(c, e, ov, oc, dv, d);
      #1;
      clear = 0; equals = 0; op_valid = 0; digit_valid = 0;
   endtask

   task automatic dig(input int d);  key(0, 0, 0, 0, 1, d); endtask
   task automatic opk(input int o);  key(0, 0, 1, o, 0, 0); endtask
   task automatic eqk();             key(0, 1, 0, 0, 0, 0); endtask
   task automatic clr();             key(1, 0, 0, 0, 0, 0); endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_a", 32'(a), 32'd0);
      chk("reset_display", 32'(display), 32'd0);
      chk("reset_selects", {28'd0, multiply, divide, subtract, add}, 32'd0);
      chk("reset_flags", {30'd0, error, overflow}, 32'd0);
      rst_n = 1'b1;
      checking = 1;

      // 12 + 34 = 46
      dig(1); dig(2); opk(0); dig(3); dig(4);
      chk("t1_a", 32'(a), 32'd12);
      chk("t1_b", 32'(b), 32'd34);
      chk("t1_add", 32'(add), 32'd1);
      eqk();
      chk("t1_display", 32'(display), 32'd46);
      clr();

      // overflow at 65535, out-of-range digit, clear
      dig(6); dig(5); dig(5); dig(3); dig(5);
      chk("t2_a_max", 32'(a), 32'd65535);
      dig(6);
      chk("t2_overflow", 32'(overflow), 32'd1);
      chk("t2_a_held", 32'(a), 32'd65535);
      dig(12);
      clr();
      chk("t2_clear_a", 32'(a), 32'd0);
      chk("t2_clear_ovf", 32'(overflow), 32'd0);

      // divide by zero locks until clear
      dig(9); opk(2); dig(0); eqk();
      chk("t3_error", 32'(error), 32'd1);
      chk("t3_display", 32'(display), 32'd0);
      dig(5); opk(0); eqk();
      chk("t3_error_held", 32'(error), 32'd1);
      clr();
      chk("t3_clear", {a, display}, 32'd0);
      chk("t3_clear_err", 32'(error), 32'd0);

      // subtract wraps; op after result depends on chaining
      dig(3); opk(1); dig(5); eqk();
      chk("t4_wrap", 32'(display), 32'd65534);
      opk(0); dig(2); eqk();
`ifdef CALC_CHAIN_EN
      chk("t4_chain", 32'(display), 32'd0);
`else
      chk("t4_nochain_a", 32'(a), 32'd2);
      chk("t4_nochain_disp", 32'(display), 32'd2);
`endif
      clr();

      // same-cycle priority
      dig(1); opk(0); dig(2);
      key(1, 1, 0, 0, 1, 5);
      chk("t5_clear_wins", {a, b}, 32'd0);
      chk("t5_clear_sel", {28'd0, multiply, divide, subtract, add}, 32'd0);
      dig(5);
      key(0, 0, 1, 0, 1, 7);
      chk("t5_op_wins_add", 32'(add), 32'd1);
      chk("t5_digit_dropped", 32'(display), 32'd5);
      clr();

      // op replacement before B, multiply wrap, '=' without B
      dig(4); opk(3); opk(0); dig(2); eqk();
      chk("t6_replaced", 32'(display), 32'd6);
      chk("t6_add_sel", 32'(add), 32'd1);
      dig(3); dig(0); dig(0); opk(3); dig(3); dig(0); dig(0); eqk();
      chk("t6_mul_wrap", 32'(display), 32'd24464);
      dig(8); opk(1); eqk();
      chk("t6_eq_no_b", 32'(display), 32'd8);
      dig(1); eqk();
      chk("t6_sub", 32'(display), 32'd7);
      clr();

      // calculator fault reported on '='
      dig(7); opk(0); dig(1);
      inj_invalid = 1'b1;
      eqk();
      inj_invalid = 1'b0;
      chk("t7_invalid_err", 32'(error), 32'd1);
      clr();

      // asynchronous reset mid-entry of B
      dig(1); opk(0); dig(2); dig(3);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t8_async_ab", {a, b}, 32'd0);
      chk("t8_async_disp", 32'(display), 32'd0);
      chk("t8_async_sel", {28'd0, multiply, divide, subtract, add}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dig(7);
      chk("t8_after_reset", 32'(a), 32'd7);

      repeat (2) @(negedge clk);
      checking = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
